// File: rtl/apb_cmd_sequencer.sv
// Host command front end for the APB bridge: buffers commands in a small FIFO,
// issues them one at a time, and returns read data / error / timeout status.
module apb_cmd_sequencer #(
   parameter int DEPTH   = 4,
   parameter int ADDR_W  = 9,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic                         PCLK,
   input  logic                         PRESET,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic                         cmd_rw,
   input  logic [ADDR_W-1:0]            cmd_addr,
   input  logic [DATA_W-1:0]            cmd_wdata,
   output logic                         transfer,
   output logic                         READ_WRITE,
   output logic [ADDR_W-1:0]            apb_write_paddr,
   output logic [DATA_W-1:0]            apb_write_data,
   output logic [ADDR_W-1:0]            apb_read_paddr,
   input  logic                         bus_done,
   input  logic                         PSLVERR,
   input  logic [DATA_W-1:0]            apb_read_data_out,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic                         rsp_rw,
   output logic [DATA_W-1:0]            rsp_rdata,
   output logic                         rsp_err,
   output logic                         rsp_timeout,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
   output logic                         busy
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int TW = $clog2(TIMEOUT);
   localparam int EW = 1 + ADDR_W + DATA_W;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t               state_q, state_d;
   logic [EW-1:0]        mem_q [DEPTH];
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic                 xfer_q, xfer_d, rw_q, rw_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [DATA_W-1:0]    wdata_q, wdata_d;
   logic                 rsp_valid_q, rsp_valid_d, rsp_rw_q, rsp_rw_d;
   logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
   logic                 rsp_err_q, rsp_err_d, rsp_tmo_q, rsp_tmo_d;

   logic                 push, pop;
   logic                 head_rw;
   logic [ADDR_W-1:0]    head_addr;
   logic [DATA_W-1:0]    head_wdata;

   // Ready is forced low combinationally while reset is asserted.
   assign cmd_ready = ~PRESET & (count_q != CW'(DEPTH));
   assign push      = cmd_valid & cmd_ready;
   assign pop       = (state_q == S_IDLE) && (count_q != '0);
   assign {head_rw, head_addr, head_wdata} = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
   end

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      xfer_d      = xfer_q;
      rw_d        = rw_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rw_d    = rsp_rw_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      rsp_tmo_d   = rsp_tmo_q;
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               rw_d    = head_rw;
               addr_d  = head_addr;
               wdata_d = head_rw ? '0 : head_wdata;
               xfer_d  = 1'b1;
               timer_d = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            timer_d = timer_q + TW'(1);
            // A completion on the final cycle beats the timeout.
            if (bus_done) begin
               xfer_d      = 1'b0;
               rsp_rdata_d = rw_q ? apb_read_data_out : '0;
               rsp_err_d   = PSLVERR;
               rsp_tmo_d   = 1'b0;
               rsp_rw_d    = rw_q;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end else if (timer_q == TW'(TIMEOUT-1)) begin
               xfer_d      = 1'b0;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
               rsp_tmo_d   = 1'b1;
               rsp_rw_d    = rw_q;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (push) mem_q[wr_ptr_q] <= {cmd_rw, cmd_addr, cmd_wdata};
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         timer_q     <= '0;
         xfer_q      <= 1'b0;
         rw_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rw_q    <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         rsp_tmo_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         timer_q     <= timer_d;
         xfer_q      <= xfer_d;
         rw_q        <= rw_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rw_q    <= rsp_rw_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         rsp_tmo_q   <= rsp_tmo_d;
      end
   end

   assign transfer        = xfer_q;
   assign READ_WRITE      = rw_q;
   assign apb_write_paddr = addr_q;
   assign apb_read_paddr  = addr_q;
   assign apb_write_data  = wdata_q;
   assign rsp_valid       = rsp_valid_q;
   assign rsp_rw          = rsp_rw_q;
   assign rsp_rdata       = rsp_rdata_q;
   assign rsp_err         = rsp_err_q;
   assign rsp_timeout     = rsp_tmo_q;
   assign fifo_count      = count_q;
   assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// Scoreboard bench: a bus-side responder/monitor predicts responses into a
// queue; a separate response monitor pops and compares on each handshake.
module tb_apb_cmd_sequencer;
   localparam int DEPTH = 4, ADDR_W = 9, DATA_W = 8, TIMEOUT = 16;
   localparam int CW = $clog2(DEPTH+1);

   logic PCLK = 1'b0, PRESET = 1'b1;
   logic cmd_valid, cmd_ready, cmd_rw;
   logic [ADDR_W-1:0] cmd_addr, apb_write_paddr, apb_read_paddr;
   logic [DATA_W-1:0] cmd_wdata, apb_write_data, apb_read_data_out, rsp_rdata;
   logic transfer, READ_WRITE, bus_done, PSLVERR;
   logic rsp_valid, rsp_ready, rsp_rw, rsp_err, rsp_timeout, busy;
   logic [CW-1:0] fifo_count;

   always #5 PCLK = ~PCLK;

   apb_cmd_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .transfer(transfer), .READ_WRITE(READ_WRITE),
      .apb_write_paddr(apb_write_paddr), .apb_write_data(apb_write_data),
      .apb_read_paddr(apb_read_paddr),
      .bus_done(bus_done), .PSLVERR(PSLVERR), .apb_read_data_out(apb_read_data_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rw(rsp_rw),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .fifo_count(fifo_count), .busy(busy)
   );

   typedef struct { logic rw; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wdata; } cmd_t;
   typedef struct { logic rw; logic [DATA_W-1:0] rdata; logic err; logic tmo; } rsp_t;

   cmd_t cmd_q[$];
   rsp_t exp_q[$];
   int total = 0, bad = 0;
   int force_delay = -1, force_err = -1, force_rdata = -1;
   bit hold_rsp = 1'b0, stray_all = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Bus side: accepted-command order, occupancy model, bridge responder.
   initial begin : bus_mon
      int acc, iss, hi, done_at, r;
      bit in_xfer, e;
      logic [DATA_W-1:0] d;
      cmd_t cur;
      acc = 0; iss = 0; hi = 0; done_at = 0; in_xfer = 0;
      cur = '{1'b0, '0, '0};
      bus_done = 1'b0; PSLVERR = 1'b0; apb_read_data_out = '0;
      forever begin
         @(negedge PCLK);
         bus_done = 1'b0;
         if (PRESET) begin
            chk("rst_cmd_ready", cmd_ready, 0);
            cmd_q.delete(); acc = 0; iss = 0; in_xfer = 0;
            continue;
         end
         if (transfer && !in_xfer) begin
            in_xfer = 1; hi = 1; iss++;
            if (cmd_q.size() == 0) chk("xfer_unexpected", 1, 0);
            else cur = cmd_q.pop_front();
            chk("issue_rw", READ_WRITE, cur.rw);
            chk("issue_wpaddr", apb_write_paddr, cur.addr);
            chk("issue_rpaddr", apb_read_paddr, cur.addr);
            chk("issue_wdata", apb_write_data, cur.rw ? '0 : cur.wdata);
            if (force_delay >= 0) done_at = force_delay;
            else begin
               r = $urandom % 10;
               done_at = (r == 0) ? 0 : (r == 1) ? TIMEOUT : 1 + ($urandom % 6);
            end
            if (done_at == 0) exp_q.push_back('{cur.rw, 8'h00, 1'b1, 1'b1});
         end else if (transfer && in_xfer) begin
            hi++;
            chk("hold_rw", READ_WRITE, cur.rw);
            chk("hold_addr", apb_write_paddr, cur.addr);
            chk("hold_wdata", apb_write_data, cur.rw ? '0 : cur.wdata);
            if (hi > TIMEOUT) chk("xfer_too_long", hi, TIMEOUT);
         end else if (!transfer && in_xfer) begin
            in_xfer = 0;
            chk("xfer_len", hi, (done_at == 0) ? TIMEOUT : done_at);
            chk("addr_retained", apb_read_paddr, cur.addr);
         end
         if (in_xfer && hi == done_at) begin
            e = (force_err >= 0) ? force_err[0] : ($urandom % 4 == 0);
            d = (force_rdata >= 0) ? force_rdata[DATA_W-1:0] : DATA_W'($urandom);
            bus_done = 1'b1; PSLVERR = e; apb_read_data_out = d;
            exp_q.push_back('{cur.rw, cur.rw ? d : 8'h00, e, 1'b0});
         end else if (!in_xfer && (stray_all || $urandom % 6 == 0)) begin
            bus_done = 1'b1; PSLVERR = 1'($urandom); apb_read_data_out = DATA_W'($urandom);
         end
         chk("fifo_count", fifo_count, acc - iss);
         chk("cmd_ready", cmd_ready, (acc - iss) != DEPTH);
         if (cmd_valid && cmd_ready) begin
            acc++;
            cmd_q.push_back('{cmd_rw, cmd_addr, cmd_wdata});
         end
      end
   end

   // Host response side.
   initial begin : rsp_mon
      bit have_prev;
      rsp_t prev, e;
      have_prev = 0;
      prev = '{1'b0, '0, 1'b0, 1'b0};
      forever begin
         @(negedge PCLK);
         if (PRESET) begin exp_q.delete(); have_prev = 0; continue; end
         if (rsp_valid) begin
            chk("no_xfer_in_resp", transfer, 0);
            if (have_prev) begin
               chk("stable_rw", rsp_rw, prev.rw);
               chk("stable_rdata", rsp_rdata, prev.rdata);
               chk("stable_err", rsp_err, prev.err);
               chk("stable_tmo", rsp_timeout, prev.tmo);
            end
            if (rsp_ready) begin
               have_prev = 0;
               if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  chk("rsp_rw", rsp_rw, e.rw);
                  chk("rsp_rdata", rsp_rdata, e.rdata);
                  chk("rsp_err", rsp_err, e.err);
                  chk("rsp_timeout", rsp_timeout, e.tmo);
               end
            end else begin
               have_prev = 1;
               prev = '{rsp_rw, rsp_rdata, rsp_err, rsp_timeout};
            end
         end else have_prev = 0;
      end
   end

   initial begin : rsp_drv
      rsp_ready = 1'b0;
      forever begin
         @(posedge PCLK); #1;
         rsp_ready = hold_rsp ? 1'b0 : ($urandom % 3 != 0);
      end
   end

   task automatic push(input logic rw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      int n;
      n = 0;
      cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_wdata = d;
      forever begin
         @(negedge PCLK);
         if (cmd_ready || n > 500) break;
         n++;
      end
      @(posedge PCLK); #1;
      cmd_valid = 1'b0;
      if (n > 500) chk("push_timeout", n, 0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      do begin @(negedge PCLK); n++; end
      while ((busy || fifo_count != 0 || rsp_valid) && n < 3000);
      chk("drain_timeout", n >= 3000, 0);
      @(posedge PCLK); #1;
   endtask

   initial begin : main
      int n;
      cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      PRESET = 1'b1;
      repeat (2) @(posedge PCLK);
      #1;
      chk("rst_transfer", transfer, 0);
      chk("rst_rw", READ_WRITE, 0);
      chk("rst_wpaddr", apb_write_paddr, 0);
      chk("rst_wdata", apb_write_data, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_fields", {rsp_rw, rsp_rdata, rsp_err, rsp_timeout}, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", cmd_ready, 0);
      PRESET = 1'b0;

      force_delay = 3;
      push(1'b0, 9'h012, 8'h3C);
      drain();
      force_rdata = 8'hA5; force_err = 0;
      push(1'b1, 9'h105, 8'h77);
      drain();

      // slave error with host stalling the response
      force_err = 1; force_rdata = -1; hold_rsp = 1'b1;
      push(1'b1, 9'h0AA, 8'h00);
      push(1'b0, 9'h1F0, 8'h5A);
      n = 0;
      while (!rsp_valid && n < 200) begin @(posedge PCLK); #1; n++; end
      chk("wait_rsp_timeout", n >= 200, 0);
      repeat (5) begin
         @(posedge PCLK); #1;
         chk("held_valid", rsp_valid, 1);
         chk("held_no_issue", transfer, 0);
         chk("held_err", rsp_err, 1);
      end
      hold_rsp = 1'b0;
      drain();
      force_err = -1;

      force_delay = 0;
      push(1'b1, 9'h033, 8'h11);
      drain();

      for (int i = 0; i < 6; i++) push(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
      drain();

      // reset while a command is in flight with two more queued
      for (int i = 0; i < 3; i++) push(1'b0, ADDR_W'(9'h040 + i), DATA_W'(i));
      chk("pre_rst_count", fifo_count, 2);
      chk("pre_rst_transfer", transfer, 1);
      PRESET = 1'b1;
      @(posedge PCLK); #1;
      chk("midrst_transfer", transfer, 0);
      chk("midrst_count", fifo_count, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_rsp_valid", rsp_valid, 0);
      PRESET = 1'b0;
      stray_all = 1'b1;
      repeat (10) begin
         @(posedge PCLK); #1;
         chk("stray_rsp_valid", rsp_valid, 0);
         chk("stray_busy", busy, 0);
      end
      stray_all = 1'b0;
      force_delay = -1;

      for (int i = 0; i < 200; i++) begin
         repeat ($urandom % 3) @(posedge PCLK);
         #1;
         push(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
      end
      drain();
      chk("scoreboard_empty", exp_q.size(), 0);
      chk("cmd_queue_empty", cmd_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
